// File: rtl/slave_msg_pkg.sv
// Shared constants and types for the slave message frame parser.
// The optional checksum stage is selected by defining SLAVE_MSG_CHECKSUM_EN.
package slave_msg_pkg;

    localparam int BYTE_W  = 8;
    localparam int FIELD_W = 16;

    localparam logic [BYTE_W-1:0] HDR_BYTE0 = 8'h55;
    localparam logic [BYTE_W-1:0] HDR_BYTE1 = 8'hAA;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_HUNT_H0,
        ST_HUNT_H1,
        ST_CMD_H,
        ST_CMD_L,
        ST_LEN_H,
        ST_LEN_L,
        ST_PAYLOAD,
        ST_CSUM
    } parser_state_t;

endpackage

// File: rtl/slave_msg_parser_sat_cnt16.sv
// 16-bit event counter that sticks at 0xFFFF instead of wrapping.
module sat_cnt16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 16'd0;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/slave_msg_parser.sv
// Frame parser for the SLAVE_MSG_RX byte stream: header hunt, field capture, payload forwarding.
// Define SLAVE_MSG_CHECKSUM_EN to expect and verify a trailing checksum byte.
module slave_msg_parser
    import slave_msg_pkg::*;
#(
    parameter int MAX_LEN     = 1024,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                clk_sys_i,
    input  logic                rst_n_i,
    input  logic                rd_data_vld_i,
    input  logic [BYTE_W-1:0]   rd_data_i,
    output logic                msg_start_o,
    output logic [FIELD_W-1:0]  msg_cmd_o,
    output logic [FIELD_W-1:0]  msg_len_o,
    output logic                msg_data_vld_o,
    output logic [BYTE_W-1:0]   msg_data_o,
    output logic                msg_data_last_o,
    output logic                msg_done_o,
    output logic                msg_err_o,
    output logic [1:0]          err_code_o,
    output logic [FIELD_W-1:0]  frame_cnt_o,
    output logic [FIELD_W-1:0]  err_cnt_o
);

    localparam logic [FIELD_W-1:0] MAX_LEN_W   = FIELD_W'(MAX_LEN);
    localparam logic [FIELD_W-1:0] TIMEOUT_M1  = FIELD_W'(TIMEOUT_CYC - 1);

    parser_state_t       state;
    logic [BYTE_W-1:0]   cmd_h;
    logic [BYTE_W-1:0]   len_h;
    logic [FIELD_W-1:0]  cmd_shadow;
    logic [FIELD_W-1:0]  remaining;
    logic [FIELD_W-1:0]  idle_cnt;
    logic [FIELD_W-1:0]  len_full;
    logic                timeout_hit;
`ifdef SLAVE_MSG_CHECKSUM_EN
    logic [BYTE_W-1:0]   csum;
`endif

    assign len_full = {len_h, rd_data_i};

    // A byte on the expiry cycle takes priority, so only idle cycles can time out.
    assign timeout_hit = !rd_data_vld_i && (state != ST_HUNT_H0) && (idle_cnt == TIMEOUT_M1);

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state           <= ST_HUNT_H0;
            cmd_h           <= '0;
            len_h           <= '0;
            cmd_shadow      <= '0;
            remaining       <= '0;
            idle_cnt        <= '0;
`ifdef SLAVE_MSG_CHECKSUM_EN
            csum            <= '0;
`endif
            msg_start_o     <= 1'b0;
            msg_cmd_o       <= '0;
            msg_len_o       <= '0;
            msg_data_vld_o  <= 1'b0;
            msg_data_o      <= '0;
            msg_data_last_o <= 1'b0;
            msg_done_o      <= 1'b0;
            msg_err_o       <= 1'b0;
            err_code_o      <= ERR_NONE;
        end else begin
            msg_start_o     <= 1'b0;
            msg_data_vld_o  <= 1'b0;
            msg_data_last_o <= 1'b0;
            msg_done_o      <= 1'b0;
            msg_err_o       <= 1'b0;

            if (rd_data_vld_i || (state == ST_HUNT_H0) || timeout_hit) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 16'd1;
            end

            if (timeout_hit) begin
                msg_err_o  <= 1'b1;
                err_code_o <= ERR_TIMEOUT;
                state      <= ST_HUNT_H0;
            end else if (rd_data_vld_i) begin
`ifdef SLAVE_MSG_CHECKSUM_EN
                if (state inside {ST_CMD_H, ST_CMD_L, ST_LEN_H, ST_LEN_L, ST_PAYLOAD}) begin
                    csum <= csum + rd_data_i;
                end
`endif
                case (state)
                    ST_HUNT_H0: begin
                        if (rd_data_i == HDR_BYTE0) state <= ST_HUNT_H1;
                    end
                    ST_HUNT_H1: begin
                        if (rd_data_i == HDR_BYTE1) begin
                            state <= ST_CMD_H;
`ifdef SLAVE_MSG_CHECKSUM_EN
                            csum  <= '0;
`endif
                        end else if (rd_data_i != HDR_BYTE0) begin
                            state <= ST_HUNT_H0;
                        end
                    end
                    ST_CMD_H: begin
                        cmd_h <= rd_data_i;
                        state <= ST_CMD_L;
                    end
                    ST_CMD_L: begin
                        cmd_shadow <= {cmd_h, rd_data_i};
                        state      <= ST_LEN_H;
                    end
                    ST_LEN_H: begin
                        len_h <= rd_data_i;
                        state <= ST_LEN_L;
                    end
                    ST_LEN_L: begin
                        if (len_full > MAX_LEN_W) begin
                            msg_err_o  <= 1'b1;
                            err_code_o <= ERR_LEN;
                            state      <= ST_HUNT_H0;
                        end else begin
                            msg_start_o <= 1'b1;
                            msg_cmd_o   <= cmd_shadow;
                            msg_len_o   <= len_full;
                            remaining   <= len_full;
                            if (len_full != 16'd0) begin
                                state <= ST_PAYLOAD;
                            end else begin
`ifdef SLAVE_MSG_CHECKSUM_EN
                                state <= ST_CSUM;
`else
                                msg_done_o <= 1'b1;
                                state      <= ST_HUNT_H0;
`endif
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        msg_data_vld_o <= 1'b1;
                        msg_data_o     <= rd_data_i;
                        remaining      <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            msg_data_last_o <= 1'b1;
`ifdef SLAVE_MSG_CHECKSUM_EN
                            state <= ST_CSUM;
`else
                            msg_done_o <= 1'b1;
                            state      <= ST_HUNT_H0;
`endif
                        end
                    end
`ifdef SLAVE_MSG_CHECKSUM_EN
                    ST_CSUM: begin
                        if (rd_data_i == csum) begin
                            msg_done_o <= 1'b1;
                        end else begin
                            msg_err_o  <= 1'b1;
                            err_code_o <= ERR_CSUM;
                        end
                        state <= ST_HUNT_H0;
                    end
`endif
                    default: state <= ST_HUNT_H0;
                endcase
            end
        end
    end

    // Counters follow the registered pulses, so they step one cycle after done/err.
    sat_cnt16 u_frame_cnt (
        .clk   (clk_sys_i),
        .rst_n (rst_n_i),
        .inc   (msg_done_o),
        .count (frame_cnt_o)
    );

    sat_cnt16 u_err_cnt (
        .clk   (clk_sys_i),
        .rst_n (rst_n_i),
        .inc   (msg_err_o),
        .count (err_cnt_o)
    );

endmodule

// File: tb/tb_slave_msg_parser.sv
// Directed self-checking bench for slave_msg_parser; follows SLAVE_MSG_CHECKSUM_EN if defined.
module tb_slave_msg_parser;

    logic        clk_sys_i = 1'b0;
    logic        rst_n_i;
    logic        rd_data_vld_i;
    logic [7:0]  rd_data_i;
    logic        msg_start_o;
    logic [15:0] msg_cmd_o;
    logic [15:0] msg_len_o;
    logic        msg_data_vld_o;
    logic [7:0]  msg_data_o;
    logic        msg_data_last_o;
    logic        msg_done_o;
    logic        msg_err_o;
    logic [1:0]  err_code_o;
    logic [15:0] frame_cnt_o;
    logic [15:0] err_cnt_o;

    int errors = 0;
    int checks = 0;
    int exp_frames = 0;
    int exp_errs = 0;

    always #5 clk_sys_i = ~clk_sys_i;

    slave_msg_parser #(
        .MAX_LEN     (1024),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk_sys_i       (clk_sys_i),
        .rst_n_i         (rst_n_i),
        .rd_data_vld_i   (rd_data_vld_i),
        .rd_data_i       (rd_data_i),
        .msg_start_o     (msg_start_o),
        .msg_cmd_o       (msg_cmd_o),
        .msg_len_o       (msg_len_o),
        .msg_data_vld_o  (msg_data_vld_o),
        .msg_data_o      (msg_data_o),
        .msg_data_last_o (msg_data_last_o),
        .msg_done_o      (msg_done_o),
        .msg_err_o       (msg_err_o),
        .err_code_o      (err_code_o),
        .frame_cnt_o     (frame_cnt_o),
        .err_cnt_o       (err_cnt_o)
    );

    // Drive one cycle at a negedge; on return the outputs reflect that byte.
    task automatic cyc(input logic v, input logic [7:0] b);
        rd_data_vld_i = v;
        rd_data_i     = b;
        @(negedge clk_sys_i);
    endtask

    task automatic test_reset;
        rst_n_i = 1'b0;
        rd_data_vld_i = 1'b0;
        rd_data_i = 8'h00;
        #3;
        checks++;
        if ({msg_start_o, msg_cmd_o, msg_len_o, msg_data_vld_o, msg_data_o, msg_data_last_o,
             msg_done_o, msg_err_o, err_code_o, frame_cnt_o, err_cnt_o} !== 78'd0)
            $display("[TB] FAIL reset_outputs: some output nonzero, cmd=%h len=%h cnt=%0d/%0d",
                     msg_cmd_o, msg_len_o, frame_cnt_o, err_cnt_o);
        @(negedge clk_sys_i);
        rst_n_i = 1'b1;
        @(negedge clk_sys_i);
    endtask

    task automatic test_good_frame;
        logic [7:0] f[$];
        f = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
`ifdef SLAVE_MSG_CHECKSUM_EN
        f.push_back(8'h6C);
`endif
        for (int i = 0; i < f.size(); i++) begin
            cyc(1'b1, f[i]);
            checks++;
            if (msg_start_o !== (i == 5)) begin
                errors++;
                $display("[TB] FAIL good_start byte %0d: got %b want %b", i, msg_start_o, (i == 5));
            end
            if (i == 5) begin
                checks++;
                if ({msg_cmd_o, msg_len_o} !== {16'h0102, 16'd3}) begin
                    errors++;
                    $display("[TB] FAIL good_cmd_len: got %h/%0d want 0102/3", msg_cmd_o, msg_len_o);
                end
            end
            checks++;
            if (msg_data_vld_o !== (i >= 6 && i <= 8)) begin
                errors++;
                $display("[TB] FAIL good_data_vld byte %0d: got %b", i, msg_data_vld_o);
            end
            if (i >= 6 && i <= 8) begin
                checks++;
                if ({msg_data_o, msg_data_last_o} !== {f[i], (i == 8)}) begin
                    errors++;
                    $display("[TB] FAIL good_data byte %0d: got %h last=%b want %h last=%b",
                             i, msg_data_o, msg_data_last_o, f[i], (i == 8));
                end
            end
            checks++;
            if ({msg_done_o, msg_err_o} !== {(i == f.size() - 1), 1'b0}) begin
                errors++;
                $display("[TB] FAIL good_done byte %0d: got done=%b err=%b", i, msg_done_o, msg_err_o);
            end
        end
        exp_frames++;
        cyc(1'b0, 8'h00);
        checks++;
        if (frame_cnt_o !== 16'(exp_frames)) begin
            errors++;
            $display("[TB] FAIL good_frame_cnt: got %0d want %0d", frame_cnt_o, exp_frames);
        end
    endtask

`ifdef SLAVE_MSG_CHECKSUM_EN
    task automatic test_bad_csum;
        logic [7:0] f[$];
        f = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
        for (int i = 0; i < f.size(); i++) cyc(1'b1, f[i]);
        checks++;
        if ({msg_err_o, msg_done_o, err_code_o} !== {1'b1, 1'b0, 2'd1}) begin
            errors++;
            $display("[TB] FAIL bad_csum: got err=%b done=%b code=%0d want 1/0/1",
                     msg_err_o, msg_done_o, err_code_o);
        end
        exp_errs++;
        cyc(1'b0, 8'h00);
        checks++;
        if (err_cnt_o !== 16'(exp_errs)) begin
            errors++;
            $display("[TB] FAIL bad_csum_err_cnt: got %0d want %0d", err_cnt_o, exp_errs);
        end
    endtask
`endif

    task automatic test_back_to_back;
        logic [7:0] f[$];
        logic [7:0] seen[$];
        logic [7:0] want[$];
        int starts = 0;
        int dones = 0;
        f = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
`ifdef SLAVE_MSG_CHECKSUM_EN
        f.push_back(8'h6C);
`endif
        f.push_back(8'h55); f.push_back(8'hAA); f.push_back(8'h12); f.push_back(8'h34);
        f.push_back(8'h00); f.push_back(8'h02); f.push_back(8'hA5); f.push_back(8'h5A);
`ifdef SLAVE_MSG_CHECKSUM_EN
        f.push_back(8'h47);
`endif
        want = '{8'h11, 8'h22, 8'h33, 8'hA5, 8'h5A};
        for (int i = 0; i < f.size(); i++) begin
            cyc(1'b1, f[i]);
            if (msg_data_vld_o) seen.push_back(msg_data_o);
            if (msg_start_o) starts++;
            if (msg_done_o) dones++;
        end
        checks++;
        if (starts != 2 || dones != 2) begin
            errors++;
            $display("[TB] FAIL b2b_counts: starts=%0d dones=%0d want 2/2", starts, dones);
        end
        checks++;
        if (seen.size() != 5) begin
            errors++;
            $display("[TB] FAIL b2b_payload_size: got %0d want 5", seen.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (seen[k] !== want[k]) begin
                    errors++;
                    $display("[TB] FAIL b2b_payload[%0d]: got %h want %h", k, seen[k], want[k]);
                end
            end
        end
        checks++;
        if ({msg_cmd_o, msg_len_o} !== {16'h1234, 16'd2}) begin
            errors++;
            $display("[TB] FAIL b2b_cmd_len: got %h/%0d want 1234/2", msg_cmd_o, msg_len_o);
        end
        exp_frames += 2;
        cyc(1'b0, 8'h00);
        checks++;
        if (frame_cnt_o !== 16'(exp_frames)) begin
            errors++;
            $display("[TB] FAIL b2b_frame_cnt: got %0d want %0d", frame_cnt_o, exp_frames);
        end
    endtask

    task automatic test_resync_zero_len;
        logic [7:0] f[$];
        int done_idx;
        f = '{8'h55, 8'h55, 8'hAA, 8'h00, 8'h05, 8'h00, 8'h00};
`ifdef SLAVE_MSG_CHECKSUM_EN
        f.push_back(8'h05);
`endif
        done_idx = f.size() - 1;
        for (int i = 0; i < f.size(); i++) begin
            cyc(1'b1, f[i]);
            checks++;
            if ({msg_start_o, msg_done_o, msg_data_vld_o} !== {(i == 6), (i == done_idx), 1'b0}) begin
                errors++;
                $display("[TB] FAIL resync byte %0d: start=%b done=%b vld=%b", i,
                         msg_start_o, msg_done_o, msg_data_vld_o);
            end
            if (i == 6) begin
                checks++;
                if ({msg_cmd_o, msg_len_o} !== {16'h0005, 16'd0}) begin
                    errors++;
                    $display("[TB] FAIL resync_cmd_len: got %h/%0d want 0005/0", msg_cmd_o, msg_len_o);
                end
            end
        end
        exp_frames++;
        cyc(1'b0, 8'h00);
        checks++;
        if (frame_cnt_o !== 16'(exp_frames)) begin
            errors++;
            $display("[TB] FAIL resync_frame_cnt: got %0d want %0d", frame_cnt_o, exp_frames);
        end
    endtask

    task automatic test_len_err;
        logic [7:0] f[$];
        f = '{8'h55, 8'hAA, 8'h00, 8'h07, 8'h04, 8'h01};
        for (int i = 0; i < f.size(); i++) cyc(1'b1, f[i]);
        checks++;
        if ({msg_err_o, err_code_o, msg_start_o} !== {1'b1, 2'd2, 1'b0}) begin
            errors++;
            $display("[TB] FAIL len_err: got err=%b code=%0d start=%b want 1/2/0",
                     msg_err_o, err_code_o, msg_start_o);
        end
        exp_errs++;
        cyc(1'b1, 8'h11);
        cyc(1'b1, 8'h22);
        checks++;
        if ({msg_data_vld_o, msg_start_o, msg_err_o} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL len_err_hunt: got vld=%b start=%b err=%b", msg_data_vld_o,
                     msg_start_o, msg_err_o);
        end
        checks++;
        if (err_cnt_o !== 16'(exp_errs)) begin
            errors++;
            $display("[TB] FAIL len_err_cnt: got %0d want %0d", err_cnt_o, exp_errs);
        end
    endtask

    task automatic test_timeout;
        logic [7:0] tail[$];
        int early = 0;
        cyc(1'b1, 8'h55); cyc(1'b1, 8'hAA); cyc(1'b1, 8'h01);
        for (int i = 1; i <= 15; i++) begin
            cyc(1'b0, 8'h00);
            if (msg_err_o) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("[TB] FAIL timeout_early: got %0d early err pulses want 0", early);
        end
        cyc(1'b0, 8'h00);
        checks++;
        if ({msg_err_o, err_code_o} !== {1'b1, 2'd3}) begin
            errors++;
            $display("[TB] FAIL timeout_err: got err=%b code=%0d want 1/3", msg_err_o, err_code_o);
        end
        exp_errs++;
        cyc(1'b0, 8'h00);
        checks++;
        if (err_cnt_o !== 16'(exp_errs)) begin
            errors++;
            $display("[TB] FAIL timeout_err_cnt: got %0d want %0d", err_cnt_o, exp_errs);
        end

        cyc(1'b1, 8'h55); cyc(1'b1, 8'hAA); cyc(1'b1, 8'h01);
        for (int i = 1; i <= 15; i++) cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h02);
        checks++;
        if (msg_err_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_byte_wins: got err=%b want 0", msg_err_o);
        end
        tail = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
`ifdef SLAVE_MSG_CHECKSUM_EN
        tail.push_back(8'h6C);
`endif
        for (int i = 0; i < tail.size(); i++) cyc(1'b1, tail[i]);
        checks++;
        if ({msg_done_o, msg_err_o} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL timeout_late_frame: got done=%b err=%b want 1/0", msg_done_o, msg_err_o);
        end
        exp_frames++;
        cyc(1'b0, 8'h00);
    endtask

    task automatic test_reset_midframe;
        logic [7:0] f[$];
        f = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h00, 8'h03, 8'h11};
        for (int i = 0; i < f.size(); i++) cyc(1'b1, f[i]);
        rd_data_vld_i = 1'b0;
        #2 rst_n_i = 1'b0;
        #1;
        checks++;
        if ({msg_start_o, msg_cmd_o, msg_len_o, msg_data_vld_o, msg_data_o, msg_data_last_o,
             msg_done_o, msg_err_o, err_code_o, frame_cnt_o, err_cnt_o} !== 78'd0) begin
            errors++;
            $display("[TB] FAIL midframe_reset: outputs not cleared, cmd=%h data=%h cnt=%0d/%0d",
                     msg_cmd_o, msg_data_o, frame_cnt_o, err_cnt_o);
        end
        @(negedge clk_sys_i);
        rst_n_i = 1'b1;
        exp_frames = 0;
        exp_errs = 0;
        @(negedge clk_sys_i);
        test_good_frame();
        checks++;
        if (err_cnt_o !== 16'd0) begin
            errors++;
            $display("[TB] FAIL midframe_no_err: got err_cnt=%0d want 0", err_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
`ifdef SLAVE_MSG_CHECKSUM_EN
        test_bad_csum();
        test_good_frame();
`endif
        test_back_to_back();
        test_resync_zero_len();
        test_len_err();
        test_timeout();
        checks++;
        if ({frame_cnt_o, err_cnt_o} !== {16'(exp_frames), 16'(exp_errs)}) begin
            errors++;
            $display("[TB] FAIL totals: got %0d/%0d want %0d/%0d", frame_cnt_o, err_cnt_o,
                     exp_frames, exp_errs);
        end
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/slave_msg_parser.md
# slave_msg_parser

Byte-stream frame parser that sits directly downstream of the slave message receiver. It consumes the `rd_data_vld` / `rd_data` byte stream recovered from the SLAVE_MSG_RX lane and delineates frames. Each frame consists of a header, a command, a length, a payload and an optional checksum. The parser presents the command, the length and a payload stream with start, last, done and error indications, which the command-dispatch logic in the `clk_sys_i` domain consumes.

## Interface
- `MAX_LEN`, 1024: largest accepted payload length in bytes; a larger length field is a length error.
- `TIMEOUT_CYC`, 65535: idle `clk_sys_i` cycles allowed between bytes inside a frame before the frame is aborted.
- `clk_sys_i`  in  1  system clock; the only clock.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `rd_data_vld_i`  in  1  byte strobe from the receiver; may be high on every cycle.
- `rd_data_i`  in  8  received byte.
- `msg_start_o`  out  1  one-cycle pulse; `msg_cmd_o` and `msg_len_o` are valid from this cycle.
- `msg_cmd_o`  out  16  command field; held until the next `msg_start_o`.
- `msg_len_o`  out  16  payload length; held until the next `msg_start_o`.
- `msg_data_vld_o`  out  1  payload byte strobe.
- `msg_data_o`  out  8  payload byte.
- `msg_data_last_o`  out  1  high with the final payload byte.
- `msg_done_o`  out  1  one-cycle pulse; frame accepted.
- `msg_err_o`  out  1  one-cycle pulse; frame rejected.
- `err_code_o`  out  2  error cause, held until the next error: 1 = checksum, 2 = length, 3 = timeout.
- `frame_cnt_o`  out  16  count of accepted frames; saturates at 0xFFFF.
- `err_cnt_o`  out  16  count of rejected frames; saturates at 0xFFFF.

## Operation
- Frame layout:
  - 0x55, then 0xAA;
  - CMD_H, CMD_L;
  - LEN_H, LEN_L;
  - LEN payload bytes;
  - CSUM.
- CSUM is the 8-bit sum, modulo 256, of the CMD, LEN and payload bytes.
- Header hunt:
  - In HUNT_H0, a byte of 0x55 moves to HUNT_H1; any other byte stays in HUNT_H0.
  - In HUNT_H1, 0xAA moves to CMD_H; 0x55 stays in HUNT_H1; any other byte returns to HUNT_H0.
- Field states: CMD_H → CMD_L → LEN_H → LEN_L. Each transition consumes one valid byte.
- On the LEN_L byte, the next state is chosen as follows:
  - Length > `MAX_LEN`: `msg_err_o` with code 2, then HUNT_H0. No `msg_start_o` is issued.
  - Length = 0: `msg_start_o`, then CSUM. With checksum compiled out, `msg_start_o` and `msg_done_o` are issued together.
  - Otherwise: `msg_start_o`, then PAYLOAD.
- PAYLOAD:
  - Each valid byte is forwarded and the 16-bit remaining-byte counter is decremented.
  - When the counter reaches 1, that byte carries `msg_data_last_o` and the state moves to CSUM.
- CSUM:
  - A byte matching the sum gives `msg_done_o` and increments `frame_cnt_o`.
  - A mismatch gives `msg_err_o` with code 1 and increments `err_cnt_o`.
  - The state then returns to HUNT_H0.
- Every error pulse increments `err_cnt_o`.
- Timeout:
  - The idle counter clears on every valid byte.
  - In any state other than HUNT_H0, the frame is aborted when the counter reaches `TIMEOUT_CYC`: `msg_err_o` with code 3, then HUNT_H0.
  - The HUNT_H0 exemption also means an abort issued from HUNT_H1 is a timeout error.
  - If a byte arrives on the same cycle the counter reaches `TIMEOUT_CYC`, the byte wins and no timeout is raised.
- Payload bytes already forwarded are not retracted on error. The consumer discards the frame on `msg_err_o`.

## Timing
- All outputs are registered.
- Latency is 1 cycle from an accepted `rd_data_vld_i` byte to the corresponding `msg_start_o`, `msg_data_vld_o`, `msg_done_o` or `msg_err_o`.
- There is no backpressure: the consumer must accept one byte per cycle.
- Back-to-back frames with zero idle cycles between them are supported.
- Reset values: every output is 0, the state is HUNT_H0, and the counters and checksum accumulator are 0.
- An `rst_n_i` assertion mid-frame drops the frame immediately with no error pulse. The hunt restarts after release.

## Configuration
- `SLAVE_MSG_CHECKSUM_EN` defined:
  - the CSUM state and accumulator exist;
  - error code 1 is possible.
- `SLAVE_MSG_CHECKSUM_EN` undefined:
  - there is no CSUM byte, and the frame ends after the last payload byte (or after LEN_L when length = 0);
  - `msg_done_o` is issued in the same cycle as `msg_data_last_o`;
  - error code 1 never occurs.

## Structure
- Shared package `slave_msg_pkg`:
  - header constants 0x55 and 0xAA;
  - the state enum;
  - error-code constants;
  - frame-field widths.
- One sub-module, `sat_cnt16`: a saturating 16-bit counter, instantiated twice (for `frame_cnt_o` and `err_cnt_o`).

## Test plan
- Frame 55 AA 01 02 00 03 11 22 33 6C, bytes back-to-back → `msg_start_o` with cmd 0x0102 and len 3; bytes 11, 22, 33 with last on 33; `msg_done_o`; `frame_cnt_o` = 1.
- Same frame with CSUM 0x00 → `msg_err_o` with code 1; `err_cnt_o` = 1; a following good frame is accepted.
- Stream 55 55 AA 00 05 00 00 05 → resync on the second 0x55; zero-length frame accepted; no `msg_data_vld_o`.
- Length 0x0401 with `MAX_LEN` = 1024 → `msg_err_o` with code 2; no `msg_start_o`; parser returns to HUNT_H0.
- With `TIMEOUT_CYC` = 16, stop after the CMD_H byte for 16 cycles → `msg_err_o` with code 3; a byte arriving on cycle 16 instead → no timeout.
- Assert `rst_n_i` mid-payload → all outputs 0 asynchronously; the next complete frame is parsed correctly.
